wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter PC_W, default 32, instruction PC width.
REQ-004 wb_in_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 wb_in_rstL  in  1  reset, asynchronous assert, active-low.
REQ-006 ms_to_wb_valid  in  1  upstream (memory stage) offers a dual-line bundle.
REQ-007 wb_allowin  out  1  stage accepts a bundle this cycle.
REQ-008 lineN_v / lineN_we / lineN_waddr / lineN_wdata / lineN_pc, N=1,2  in  1/1/ADDR_W/DATA_W/PC_W  per-line valid, write enable, destination, result, PC.
REQ-009 wb_stall  in  1  external hold; bundle may not leave while high.
REQ-010 wb_flush  in  1  cancel the held bundle.
REQ-011 rf_we1, rf_waddr1, rf_wdata1, rf_we2, rf_waddr2, rf_wdata2  out  1/ADDR_W/DATA_W ×2  register-file write bus, packed {we2,waddr2,wdata2,we1,waddr1,wdata1}.
REQ-012 retire_cnt  out  32  retired-instruction counter.
REQ-013 debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  PC_W/4/ADDR_W/DATA_W  trace port (present only under REQ-030).

Function
REQ-014 Internal state: wb_valid flag plus one registered bundle (both lines' v, we, waddr, wdata, pc).
REQ-015 ready_go = !wb_stall && (trace condition of REQ-031 when compiled in); wb_allowin = !wb_valid || ready_go.
REQ-016 On an edge where wb_allowin && ms_to_wb_valid && !wb_flush: capture bundle, wb_valid <= 1; latency upstream-to-rf bus one cycle.
REQ-017 On an edge where wb_allowin && !ms_to_wb_valid: wb_valid <= 0.
REQ-018 wb_flush high: next edge wb_valid <= 0, no capture that cycle, no retire count; combinational rf_weN forced 0 in the flush cycle.
REQ-019 rf_weN = wb_valid && lineN_v && lineN_we && (waddrN != 0) from the registered bundle; asserted every cycle the bundle is held (idempotent rewrites allowed).
REQ-020 Same-address rule: both lines enabled with equal waddr -> rf_we1 forced 0, line 2 data wins.
REQ-021 rf_waddrN / rf_wdataN drive registered values unconditionally.
REQ-022 retire_cnt += (line1_v + line2_v) on the edge the bundle leaves (wb_valid && ready_go && !wb_flush); 32-bit wrap-around 0xFFFFFFFF -> 0x00000000 (or 0x00000001 for two).
REQ-023 Leave and new capture on the same edge are permitted (back-to-back bundles, no bubble).

Reset
REQ-024 wb_rstL low: immediately wb_valid=0, trace state=SLOT1, retire_cnt=0, bundle registers 0.
REQ-025 During reset all outputs: rf_we1=rf_we2=0, addresses/data 0, wb_allowin=1, debug outputs 0.
REQ-026 Reset mid-bundle discards the bundle without counting it; first post-reset edge may capture.

Configuration
REQ-030 Macro WB_SERIAL_TRACE_EN compiles in the single-line trace port and the serialising FSM; absent, debug ports are not present and ready_go = !wb_stall.
REQ-031 With macro: FSM states SLOT1, SLOT2; SLOT1 with both lines valid and !wb_stall -> SLOT2, ready_go=0; SLOT2 with !wb_stall -> SLOT1, ready_go=1; SLOT1 with one valid line -> ready_go=!wb_stall, stays SLOT1; wb_flush returns to SLOT1.
REQ-032 With macro: SLOT1 presents line 1 (or the sole valid line), SLOT2 presents line 2; debug_wb_rf_we = {4{rf write of that line per REQ-019/020}}; debug outputs 0 when wb_valid=0.
REQ-033 rf write bus behaviour (REQ-019..021) is identical with and without the macro.

Verification
REQ-040 Reset: hold wb_rstL=0 mid-transfer -> rf_we1=rf_we2=0, wb_allowin=1, retire_cnt=0 without waiting for an edge.
REQ-041 Bundle line1 {we,5,0x11}, line2 {we,7,0x22} -> next cycle rf_we1=1 waddr1=5, rf_we2=1 waddr2=7, retire_cnt=2 after leave.
REQ-042 Both lines waddr=9, data 0xA/0xB -> rf_we1=0, rf_we2=1 wdata2=0xB; waddr=0 on both -> no write, still counted.
REQ-043 wb_stall high 3 cycles with bundle held -> wb_allowin=0, retire_cnt unchanged, counts once on release; wb_flush during stall -> no count, wb_valid=0 next cycle.
REQ-044 Preload retire_cnt=0xFFFFFFFF via 2^32-1 count path (or force), retire a 2-line bundle -> 0x00000001.
REQ-045 With WB_SERIAL_TRACE_EN, continuous dual-line bundles -> wb_allowin alternates 0/1, debug_wb_pc shows line1 pc then line2 pc, one bundle per two cycles.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: holds one dual-line bundle, drives the two-port register-file write bus
// and counts retired instructions. Define WB_SERIAL_TRACE_EN to add the one-line trace port.
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_W   = 32
) (
    input  logic              wb_in_clk,
    input  logic              wb_in_rstL,
    input  logic              ms_to_wb_valid,
    output logic              wb_allowin,
    input  logic              line1_v,
    input  logic              line1_we,
    input  logic [ADDR_W-1:0] line1_waddr,
    input  logic [DATA_W-1:0] line1_wdata,
    input  logic [PC_W-1:0]   line1_pc,
    input  logic              line2_v,
    input  logic              line2_we,
    input  logic [ADDR_W-1:0] line2_waddr,
    input  logic [DATA_W-1:0] line2_wdata,
    input  logic [PC_W-1:0]   line2_pc,
    input  logic              wb_stall,
    input  logic              wb_flush,
    output logic              rf_we1,
    output logic [ADDR_W-1:0] rf_waddr1,
    output logic [DATA_W-1:0] rf_wdata1,
    output logic              rf_we2,
    output logic [ADDR_W-1:0] rf_waddr2,
    output logic [DATA_W-1:0] rf_wdata2,
    output logic [31:0]       retire_cnt
`ifdef WB_SERIAL_TRACE_EN
    ,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

    typedef struct packed {
        logic              v;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [PC_W-1:0]   pc;
    } line_t;

    logic        wb_valid_q, wb_valid_d;
    line_t       line1_q, line1_d, line2_q, line2_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        ready_go;
    logic        leave;
    logic        en1, en2;

    always_comb begin
        en1    = wb_valid_q && line1_q.v && line1_q.we && (line1_q.waddr != '0) && !wb_flush;
        en2    = wb_valid_q && line2_q.v && line2_q.we && (line2_q.waddr != '0) && !wb_flush;
        rf_we2 = en2;
        // Same destination on both lines: line 2 is younger, so its data wins.
        rf_we1 = en1 && !(en2 && (line1_q.waddr == line2_q.waddr));
    end

    assign rf_waddr1  = line1_q.waddr;
    assign rf_wdata1  = line1_q.wdata;
    assign rf_waddr2  = line2_q.waddr;
    assign rf_wdata2  = line2_q.wdata;
    assign retire_cnt = retire_cnt_q;

    assign wb_allowin = !wb_valid_q || ready_go;
    assign leave      = wb_valid_q && ready_go && !wb_flush;

    always_comb begin
        wb_valid_d   = wb_valid_q;
        line1_d      = line1_q;
        line2_d      = line2_q;
        retire_cnt_d = retire_cnt_q;
        if (leave) begin
            retire_cnt_d = retire_cnt_q + {31'b0, line1_q.v} + {31'b0, line2_q.v};
        end
        if (wb_flush) begin
            wb_valid_d = 1'b0;
        end else if (wb_allowin) begin
            wb_valid_d = ms_to_wb_valid;
            if (ms_to_wb_valid) begin
                line1_d = '{v: line1_v, we: line1_we, waddr: line1_waddr,
                            wdata: line1_wdata, pc: line1_pc};
                line2_d = '{v: line2_v, we: line2_we, waddr: line2_waddr,
                            wdata: line2_wdata, pc: line2_pc};
            end
        end
    end

    always_ff @(posedge wb_in_clk or negedge wb_in_rstL) begin
        if (!wb_in_rstL) begin
            wb_valid_q   <= 1'b0;
            line1_q      <= '0;
            line2_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            line1_q      <= line1_d;
            line2_q      <= line2_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

`ifdef WB_SERIAL_TRACE_EN
    typedef enum logic [0:0] {StSlot1, StSlot2} trace_state_e;

    trace_state_e state_q, state_d;
    logic         sel_line2;

    always_comb begin
        state_d  = state_q;
        ready_go = !wb_stall;
        unique case (state_q)
            StSlot1: begin
                // A dual-line bundle needs a second cycle so the trace port shows line 2.
                if (wb_valid_q && line1_q.v && line2_q.v) begin
                    ready_go = 1'b0;
                    if (!wb_stall) state_d = StSlot2;
                end
            end
            StSlot2: begin
                if (!wb_stall) state_d = StSlot1;
            end
        endcase
        if (wb_flush) state_d = StSlot1;
    end

    always_ff @(posedge wb_in_clk or negedge wb_in_rstL) begin
        if (!wb_in_rstL) state_q <= StSlot1;
        else             state_q <= state_d;
    end

    always_comb begin
        sel_line2         = (state_q == StSlot2) || !line1_q.v;
        debug_wb_pc       = '0;
        debug_wb_rf_we    = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (wb_valid_q) begin
            if (sel_line2) begin
                debug_wb_pc       = line2_q.pc;
                debug_wb_rf_we    = {4{rf_we2}};
                debug_wb_rf_wnum  = line2_q.waddr;
                debug_wb_rf_wdata = line2_q.wdata;
            end else begin
                debug_wb_pc       = line1_q.pc;
                debug_wb_rf_we    = {4{rf_we1}};
                debug_wb_rf_wnum  = line1_q.waddr;
                debug_wb_rf_wdata = line1_q.wdata;
            end
        end
    end
`else
    always_comb ready_go = !wb_stall;

    // PCs are held in the bundle but only observable through the trace port.
    logic unused_pc;
    assign unused_pc = ^{line1_q.pc, line2_q.pc};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, counter wrap, reset and a random
// run against a bundle-level model; serial trace sequence when WB_SERIAL_TRACE_EN is set.
module tb_wb_stage;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } ln_t;

    typedef struct {
        logic        msv, stall, flush;
        ln_t         b1, b2;
        logic        e_allow, e_we1, e_we2;
        logic        chk;
        logic [4:0]  e_a1, e_a2;
        logic [31:0] e_d2;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ms_to_wb_valid, wb_stall, wb_flush;
    ln_t         in1, in2;
    logic        wb_allowin;
    logic        rf_we1, rf_we2;
    logic [4:0]  rf_waddr1, rf_waddr2;
    logic [31:0] rf_wdata1, rf_wdata2;
    logic [31:0] retire_cnt;
`ifdef WB_SERIAL_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .ADDR_W(5), .PC_W(32)) dut (
        .wb_in_clk      (clk),
        .wb_in_rstL     (rst_n),
        .ms_to_wb_valid (ms_to_wb_valid),
        .wb_allowin     (wb_allowin),
        .line1_v        (in1.v),
        .line1_we       (in1.we),
        .line1_waddr    (in1.a),
        .line1_wdata    (in1.d),
        .line1_pc       (in1.pc),
        .line2_v        (in2.v),
        .line2_we       (in2.we),
        .line2_waddr    (in2.a),
        .line2_wdata    (in2.d),
        .line2_pc       (in2.pc),
        .wb_stall       (wb_stall),
        .wb_flush       (wb_flush),
        .rf_we1         (rf_we1),
        .rf_waddr1      (rf_waddr1),
        .rf_wdata1      (rf_wdata1),
        .rf_we2         (rf_we2),
        .rf_waddr2      (rf_waddr2),
        .rf_wdata2      (rf_wdata2),
        .retire_cnt     (retire_cnt)
`ifdef WB_SERIAL_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the bundle currently held and the number of instructions retired.
    logic        m_valid;
    ln_t         m1, m2;
    logic [31:0] m_cnt;

    function automatic ln_t ln(input logic v, input logic we, input logic [4:0] a,
                               input logic [31:0] d);
        ln_t l;
        l = '{v: v, we: we, a: a, d: d, pc: 32'h0};
        return l;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m1      = '0;
        m2      = '0;
        m_cnt   = '0;
    endtask

    task automatic drive(input logic msv, input logic st, input logic fl,
                         input ln_t b1, input ln_t b2);
        ms_to_wb_valid = msv;
        wb_stall       = st;
        wb_flush       = fl;
        in1            = b1;
        in2            = b2;
        #1;
    endtask

    task automatic model_edge();
        if (wb_flush) begin
            m_valid = 1'b0;
        end else begin
            if (m_valid && !wb_stall) m_cnt = m_cnt + 32'(m1.v) + 32'(m2.v);
            if (!m_valid || !wb_stall) begin
                if (ms_to_wb_valid) begin
                    m_valid = 1'b1;
                    m1      = in1;
                    m2      = in2;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic w1, w2;
        w1 = m_valid && m1.v && m1.we && (m1.a != 5'd0) && !wb_flush;
        w2 = m_valid && m2.v && m2.we && (m2.a != 5'd0) && !wb_flush;
        if (w1 && w2 && (m1.a == m2.a)) w1 = 1'b0;
`ifndef WB_SERIAL_TRACE_EN
        check({tag, " allowin"}, 64'(wb_allowin), 64'(!m_valid || !wb_stall));
`endif
        check({tag, " we1"}, 64'(rf_we1), 64'(w1));
        check({tag, " we2"}, 64'(rf_we2), 64'(w2));
        check({tag, " waddr1"}, 64'(rf_waddr1), 64'(m1.a));
        check({tag, " waddr2"}, 64'(rf_waddr2), 64'(m2.a));
        check({tag, " wdata1"}, 64'(rf_wdata1), 64'(m1.d));
        check({tag, " wdata2"}, 64'(rf_wdata2), 64'(m2.d));
        check({tag, " cnt"}, 64'(retire_cnt), 64'(m_cnt));
    endtask

    vec_t tbl[12];

    initial begin
        ln_t a1, a2, b1, b2, c1, c2, d1, d2, e1, e2, z;
        a1 = ln(1, 1, 5'd5, 32'h11); a2 = ln(1, 1, 5'd7, 32'h22);
        b1 = ln(1, 1, 5'd9, 32'hA);  b2 = ln(1, 1, 5'd9, 32'hB);
        c1 = ln(1, 1, 5'd0, 32'hC1); c2 = ln(1, 1, 5'd0, 32'hC2);
        d1 = ln(1, 1, 5'd3, 32'h33); d2 = ln(0, 1, 5'd4, 32'h44);
        e1 = ln(1, 1, 5'd4, 32'h55); e2 = ln(1, 1, 5'd6, 32'h66);
        z  = '0;
        // {msv,stall,flush, line1,line2, allowin,we1,we2, chk,a1,a2,d2, cnt} seen before the edge
        tbl[0]  = '{1, 0, 0, a1, a2, 1, 0, 0, 0, 0, 0, 0,     0};
        tbl[1]  = '{1, 0, 0, b1, b2, 1, 1, 1, 1, 5, 7, 'h22,  0};
        tbl[2]  = '{1, 0, 0, c1, c2, 1, 0, 1, 1, 9, 9, 'hB,   2};
        tbl[3]  = '{1, 1, 0, d1, d2, 0, 0, 0, 0, 0, 0, 0,     4};
        tbl[4]  = '{1, 1, 0, d1, d2, 0, 0, 0, 0, 0, 0, 0,     4};
        tbl[5]  = '{1, 1, 0, d1, d2, 0, 0, 0, 0, 0, 0, 0,     4};
        tbl[6]  = '{1, 0, 0, d1, d2, 1, 0, 0, 0, 0, 0, 0,     4};
        tbl[7]  = '{1, 0, 0, e1, e2, 1, 1, 0, 0, 0, 0, 0,     6};
        tbl[8]  = '{0, 1, 0, z,  z,  0, 1, 1, 0, 0, 0, 0,     7};
        tbl[9]  = '{0, 1, 1, z,  z,  0, 0, 0, 0, 0, 0, 0,     7};
        tbl[10] = '{0, 0, 0, z,  z,  1, 0, 0, 0, 0, 0, 0,     7};
        tbl[11] = '{0, 1, 0, z,  z,  1, 0, 0, 0, 0, 0, 0,     7};

        model_reset();
        ms_to_wb_valid = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0; in1 = '0; in2 = '0;
        #2;
        check("por we1", 64'(rf_we1), 64'(0));
        check("por we2", 64'(rf_we2), 64'(0));
        check("por allowin", 64'(wb_allowin), 64'(1));
        check("por cnt", 64'(retire_cnt), 64'(0));
        #10;
        rst_n = 1'b1;

`ifndef WB_SERIAL_TRACE_EN
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].msv, tbl[i].stall, tbl[i].flush, tbl[i].b1, tbl[i].b2);
            check($sformatf("vec%0d allowin", i), 64'(wb_allowin), 64'(tbl[i].e_allow));
            check($sformatf("vec%0d we1", i), 64'(rf_we1), 64'(tbl[i].e_we1));
            check($sformatf("vec%0d we2", i), 64'(rf_we2), 64'(tbl[i].e_we2));
            check($sformatf("vec%0d cnt", i), 64'(retire_cnt), 64'(tbl[i].e_cnt));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d waddr1", i), 64'(rf_waddr1), 64'(tbl[i].e_a1));
                check($sformatf("vec%0d waddr2", i), 64'(rf_waddr2), 64'(tbl[i].e_a2));
                check($sformatf("vec%0d wdata2", i), 64'(rf_wdata2), 64'(tbl[i].e_d2));
            end
            advance();
        end

        // Counter wrap: preload all-ones, then retire a two-line bundle.
        drive(1, 0, 0, a1, a2);
        advance();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(0, 0, 0, z, z);
        check_outputs("preload");
        advance();
        drive(0, 0, 0, z, z);
        check("wrap cnt", 64'(retire_cnt), 64'(32'h1));
        check_outputs("wrap");
        advance();

        for (int i = 0; i < 400; i++) begin
            ln_t r1, r2;
            r1 = '{v: ($urandom % 4) != 0, we: ($urandom % 4) != 0, a: 5'($urandom % 4),
                   d: $urandom, pc: $urandom};
            r2 = '{v: ($urandom % 4) != 0, we: ($urandom % 4) != 0, a: 5'($urandom % 4),
                   d: $urandom, pc: $urandom};
            drive(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 10) == 0, r1, r2);
            check_outputs($sformatf("rnd%0d", i));
            advance();
        end
`endif

        // Asynchronous reset while a bundle is held, then capture on the first edge after.
        drive(1, 0, 0, a1, a2);
        advance();
        drive(1, 0, 0, b1, b2);
        check("pre-rst we1", 64'(rf_we1), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst we1", 64'(rf_we1), 64'(0));
        check("rst we2", 64'(rf_we2), 64'(0));
        check("rst allowin", 64'(wb_allowin), 64'(1));
        check("rst cnt", 64'(retire_cnt), 64'(0));
        check("rst waddr1", 64'(rf_waddr1), 64'(0));
        check("rst wdata2", 64'(rf_wdata2), 64'(0));
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, b1, b2);
        check_outputs("post-rst empty");
        advance();
        drive(0, 1, 0, z, z);
        check_outputs("post-rst held");
        advance();

`ifdef WB_SERIAL_TRACE_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 7; c++) begin
            int k, h;
            ln_t s1, s2;
            k = c / 2;
            h = (c - 1) / 2;
            s1 = ln(1, 1, 5'd1, 32'h100 + 32'(k));
            s2 = ln(1, 1, 5'd2, 32'h200 + 32'(k));
            s1.pc = 32'h100 + 32'(16 * k);
            s2.pc = 32'h108 + 32'(16 * k);
            drive(1, 0, 0, s1, s2);
            check($sformatf("ser%0d allowin", c), 64'(wb_allowin), 64'(c % 2 == 0));
            if (c == 0) begin
                check("ser0 pc", 64'(debug_wb_pc), 64'(0));
                check("ser0 we", 64'(debug_wb_rf_we), 64'(0));
            end else begin
                check($sformatf("ser%0d pc", c), 64'(debug_wb_pc),
                      64'((c % 2 == 1) ? 32'h100 + 32'(16 * h) : 32'h108 + 32'(16 * h)));
                check($sformatf("ser%0d we", c), 64'(debug_wb_rf_we), 64'(4'hF));
                check($sformatf("ser%0d cnt", c), 64'(retire_cnt), 64'(2 * h));
            end
            @(posedge clk);
            #1;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
